// File: rtl/fetch_decode.sv
// fetch_decode: front-end stage of the Harvard core.
// Fetches 16-bit instruction words, decodes the opcode and register fields,
// reads operands from an 8 x 3-bit register file, and hands the result to the
// execute stage over a valid/ready handshake. Unconditional jumps and halt are
// handled locally. Branch redirects arrive from downstream.
module fetch_decode #(
    parameter int unsigned PC_W    = 8,
    parameter logic [4:0]  JMP_OP  = 5'b10001,
    parameter logic [4:0]  HALT_OP = 5'b11111
) (
    input  logic            clk,
    input  logic            reset,

    // instruction memory port
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_rdata,

    // decoded instruction towards execute
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      opcode,
    output logic [2:0]      rd_addr,
    output logic [2:0]      r1_val,
    output logic [2:0]      r2_val,
    output logic [7:0]      imm8,
    output logic [PC_W-1:0] out_pc,

    // register writeback
    input  logic            wb_en,
    input  logic [2:0]      wb_addr,
    input  logic [2:0]      wb_data,

    // branch redirect / flush
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,

    output logic            halted
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]      state_q,     state_d;
    logic [PC_W-1:0] pc_q,        pc_d;
    logic            drop_q,      drop_d;
    logic            out_valid_q, out_valid_d;
    logic            halted_q,    halted_d;
    logic [4:0]      opcode_q,    opcode_d;
    logic [2:0]      rd_addr_q,   rd_addr_d;
    logic [2:0]      r1_val_q,    r1_val_d;
    logic [2:0]      r2_val_q,    r2_val_d;
    logic [7:0]      imm8_q,      imm8_d;
    logic [PC_W-1:0] out_pc_q,    out_pc_d;
    logic [2:0]      rf_q [8];

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [4:0]      instr_op;
    logic [2:0]      instr_rd;
    logic [2:0]      instr_src1;
    logic [2:0]      instr_src2;
    logic [7:0]      instr_imm;
    logic [PC_W-1:0] jmp_target;
    logic [2:0]      src1_val;
    logic [2:0]      src2_val;

    assign instr_op   = imem_rdata[15:11];
    assign instr_rd   = imem_rdata[10:8];
    assign instr_src1 = imem_rdata[7:5];
    assign instr_src2 = imem_rdata[4:2];
    assign instr_imm  = imem_rdata[7:0];
    assign jmp_target = PC_W'(instr_imm);

    // Operand read with writeback bypass for the capture cycle
    always_comb begin
        src1_val = rf_q[instr_src1];
        src2_val = rf_q[instr_src2];
        if (wb_en && (wb_addr == instr_src1)) begin
            src1_val = wb_data;
        end
        if (wb_en && (wb_addr == instr_src2)) begin
            src2_val = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: fetch sequencing, decode capture, redirect override
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        opcode_d    = opcode_q;
        rd_addr_d   = rd_addr_q;
        r1_val_d    = r1_val_q;
        r2_val_d    = r2_val_q;
        imm8_d      = imm8_q;
        out_pc_d    = out_pc_q;

        // A stale response swallowed by the drop flag clears it wherever it lands
        if (drop_q && imem_valid) begin
            drop_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (imem_valid && !drop_q) begin
                    if (instr_op == JMP_OP) begin
                        pc_d    = jmp_target;
                        state_d = S_FETCH;
                    end else if (instr_op == HALT_OP) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        opcode_d    = instr_op;
                        rd_addr_d   = instr_rd;
                        r1_val_d    = src1_val;
                        r2_val_d    = src2_val;
                        imm8_d      = instr_imm;
                        out_pc_d    = pc_q;
                        pc_d        = pc_q + PC_W'(1);
                        out_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Redirect overrides everything above. A fetch still in flight
        // (request issued this cycle, or WAIT without its response, or a
        // second response behind a stale one) must be swallowed later.
        if (redirect_en) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            halted_d    = 1'b0;
            state_d     = S_FETCH;
            drop_d      = (state_q == S_FETCH) ||
                          ((state_q == S_WAIT) && (!imem_valid || drop_q)) ||
                          (drop_q && !imem_valid);
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            opcode_q    <= '0;
            rd_addr_q   <= '0;
            r1_val_q    <= '0;
            r2_val_q    <= '0;
            imm8_q      <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            opcode_q    <= opcode_d;
            rd_addr_q   <= rd_addr_d;
            r1_val_q    <= r1_val_d;
            r2_val_q    <= r2_val_d;
            imm8_q      <= imm8_d;
            out_pc_q    <= out_pc_d;
        end
    end

    // Register file: cleared on reset, written whenever wb_en is set
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Request is gated by reset so no fetch is signalled while reset is held
    assign imem_req  = (state_q == S_FETCH) && !reset;
    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign rd_addr   = rd_addr_q;
    assign r1_val    = r1_val_q;
    assign r2_val    = r2_val_q;
    assign imm8      = imm8_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;

endmodule
